// File: rtl/mvm_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mvm_ctrl_if
//  Purpose  : Stream handshakes and memory/accumulator controls between the
//             MVM controller and its datapath.
//  Revision : 1.0  initial release
// ============================================================================
interface mvm_ctrl_if #(
    parameter int SIZE = 3
);
    localparam int c_aw_m = $clog2(SIZE * SIZE);
    localparam int c_aw_x = $clog2(SIZE);

    logic              s_valid;
    logic              s_ready;
    logic              m_valid;
    logic              m_ready;
    logic              wr_en_m;
    logic              wr_en_x;
    logic [c_aw_m-1:0] addr_m;
    logic [c_aw_x-1:0] addr_x;
    logic              clear_acc;
    logic              en_acc;

    // Controller side
    modport master (
        input  s_valid,
        input  m_ready,
        output s_ready,
        output m_valid,
        output wr_en_m,
        output wr_en_x,
        output addr_m,
        output addr_x,
        output clear_acc,
        output en_acc
    );

    // Datapath / stream-partner side
    modport slave (
        output s_valid,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  wr_en_m,
        input  wr_en_x,
        input  addr_m,
        input  addr_x,
        input  clear_acc,
        input  en_acc
    );
endinterface
`default_nettype wire

// File: rtl/mvm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mvm_ctrl
//  Purpose  : Sequencer for the matrix-vector multiply datapath: loads the
//             matrix and vector, walks the dot products, hands out results.
//  Revision : 1.0  initial release
// ============================================================================
module mvm_ctrl #(
    parameter int SIZE = 3
) (
    input  wire logic   clk,
    input  wire logic   reset,
    mvm_ctrl_if.master  bus
);
    localparam int c_aw_m = $clog2(SIZE * SIZE);
    localparam int c_aw_x = $clog2(SIZE);
    localparam int c_cw   = $clog2(SIZE * SIZE + SIZE);

    localparam logic [c_cw-1:0]   c_n_mat     = c_cw'(SIZE * SIZE);
    localparam logic [c_cw-1:0]   c_last_load = c_cw'(SIZE * SIZE + SIZE - 1);
    localparam logic [c_aw_x-1:0] c_last_idx  = c_aw_x'(SIZE - 1);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DRAIN   = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_cw-1:0]   r_load_cnt;
    logic [c_aw_x-1:0] r_row;
    logic [c_aw_x-1:0] r_col;

    state_t            w_state_nx;
    logic [c_cw-1:0]   w_load_cnt_nx;
    logic [c_aw_x-1:0] w_row_nx;
    logic [c_aw_x-1:0] w_col_nx;

    logic              w_s_ready;
    logic              w_m_valid;
    logic              w_wr_en_m;
    logic              w_wr_en_x;
    logic [c_aw_m-1:0] w_addr_m;
    logic [c_aw_x-1:0] w_addr_x;
    logic              w_clear_acc;
    logic              w_en_acc;

    logic              w_load_is_mat;
    logic [c_aw_m-1:0] w_rc_addr;
    logic [c_aw_x-1:0] w_vec_addr;

    assign w_load_is_mat = (r_load_cnt < c_n_mat);
    assign w_rc_addr     = c_aw_m'(int'(r_row) * SIZE + int'(r_col));
    assign w_vec_addr    = c_aw_x'(r_load_cnt - c_n_mat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_LOAD;
            r_load_cnt <= '0;
            r_row      <= '0;
            r_col      <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_load_cnt <= w_load_cnt_nx;
            r_row      <= w_row_nx;
            r_col      <= w_col_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_load_cnt_nx = r_load_cnt;
        w_row_nx      = r_row;
        w_col_nx      = r_col;
        w_s_ready     = 1'b0;
        w_m_valid     = 1'b0;
        w_wr_en_m     = 1'b0;
        w_wr_en_x     = 1'b0;
        w_clear_acc   = 1'b0;
        w_en_acc      = 1'b0;
        w_addr_m      = w_rc_addr;
        w_addr_x      = r_col;

        case (r_state)
            S_LOAD: begin
                w_s_ready = 1'b1;
                // Unused address held at 0 so neither bus is X-free only by luck
                w_addr_m  = w_load_is_mat ? r_load_cnt[c_aw_m-1:0] : '0;
                w_addr_x  = w_load_is_mat ? '0 : w_vec_addr;
                if (bus.s_valid) begin
                    w_wr_en_m = w_load_is_mat;
                    w_wr_en_x = !w_load_is_mat;
                    if (r_load_cnt == c_last_load) begin
                        w_state_nx    = S_COMPUTE;
                        w_load_cnt_nx = '0;
                        w_row_nx      = '0;
                        w_col_nx      = '0;
                    end else begin
                        w_load_cnt_nx = r_load_cnt + 1'b1;
                    end
                end
            end

            S_COMPUTE: begin
                // First column of a row restarts the sum; the product it
                // fetches is added one cycle later once the read returns.
                w_clear_acc = (r_col == '0);
                w_en_acc    = (r_col != '0);
                if (r_col == c_last_idx) begin
                    w_state_nx = S_DRAIN;
                    w_col_nx   = '0;
                end else begin
                    w_col_nx   = r_col + 1'b1;
                end
            end

            S_DRAIN: begin
                w_en_acc   = 1'b1;
                w_state_nx = S_OUTPUT;
            end

            S_OUTPUT: begin
                w_m_valid = 1'b1;
                if (bus.m_ready) begin
                    if (r_row == c_last_idx) begin
                        w_state_nx    = S_LOAD;
                        w_load_cnt_nx = '0;
                        w_row_nx      = '0;
                        w_col_nx      = '0;
                    end else begin
                        w_state_nx = S_COMPUTE;
                        w_row_nx   = r_row + 1'b1;
                        w_col_nx   = '0;
                    end
                end
            end

            default: begin
                w_state_nx = S_LOAD;
            end
        endcase
    end

    assign bus.s_ready   = w_s_ready;
    assign bus.m_valid   = w_m_valid;
    assign bus.wr_en_m   = w_wr_en_m;
    assign bus.wr_en_x   = w_wr_en_x;
    assign bus.addr_m    = w_addr_m;
    assign bus.addr_x    = w_addr_x;
    assign bus.clear_acc = w_clear_acc;
    assign bus.en_acc    = w_en_acc;

endmodule
`default_nettype wire

// File: tb/tb_mvm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mvm_ctrl
//  Purpose  : Self-checking bench for mvm_ctrl with a behavioural datapath.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mvm_ctrl;
    localparam int SIZE = 3;
    localparam int NM   = SIZE * SIZE;
    localparam int NW   = NM + SIZE;
    localparam int AWM  = $clog2(NM);
    localparam int AWX  = $clog2(SIZE);

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din   = 8'h00;

    mvm_ctrl_if #(.SIZE(SIZE)) bus ();

    mvm_ctrl #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: synchronous-read memories, accumulator as data_out
    logic [7:0]  mem_m [NM];
    logic [7:0]  mem_x [SIZE];
    logic [7:0]  rd_m = 8'h00;
    logic [7:0]  rd_x = 8'h00;
    logic [15:0] acc  = 16'h0000;

    always @(posedge clk) begin
        if (bus.wr_en_m) mem_m[bus.addr_m] <= din;
        if (bus.wr_en_x) mem_x[bus.addr_x] <= din;
        rd_m <= mem_m[bus.addr_m];
        rd_x <= mem_x[bus.addr_x];
        if (bus.clear_acc)   acc <= 16'h0000;
        else if (bus.en_acc) acc <= acc + ({8'h00, rd_m} * {8'h00, rd_x});
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  prob [NW];
    logic [15:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    // Reference: y[r] = sum_c M[r][c] * x[c], truncated to 16 bits
    task automatic push_expected();
        for (int r = 0; r < SIZE; r++) begin
            int sum = 0;
            for (int c = 0; c < SIZE; c++)
                sum += int'(prob[r*SIZE+c]) * int'(prob[NM+c]);
            exp_q.push_back(16'(sum));
        end
    endtask

    task automatic set_known_problem();
        int vals [NW] = '{1, 2, 3, 2, 3, 4, 3, 4, 5, 3, 3, 3};
        for (int i = 0; i < NW; i++) prob[i] = 8'(vals[i]);
    endtask

    task automatic load_problem(input bit check);
        for (int i = 0; i < NW; i++) begin
            din         = prob[i];
            bus.s_valid = 1'b1;
            #1;
            if (check) begin
                n_checks++;
                if (bus.s_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL load_ready word %0d: got %b want 1", i, bus.s_ready);
                end
                if (i < NM) begin
                    n_checks++;
                    if (bus.wr_en_m !== 1'b1 || bus.wr_en_x !== 1'b0 || bus.addr_m !== AWM'(i)) begin
                        n_fail++;
                        $display("FAIL load_mat word %0d: wr_m=%b wr_x=%b addr_m=%0d want 1 0 %0d",
                                 i, bus.wr_en_m, bus.wr_en_x, bus.addr_m, i);
                    end
                end else begin
                    n_checks++;
                    if (bus.wr_en_x !== 1'b1 || bus.wr_en_m !== 1'b0 || bus.addr_x !== AWX'(i - NM)) begin
                        n_fail++;
                        $display("FAIL load_vec word %0d: wr_m=%b wr_x=%b addr_x=%0d want 0 1 %0d",
                                 i, bus.wr_en_m, bus.wr_en_x, bus.addr_x, i - NM);
                    end
                end
            end
            tick();
        end
        #1;
        if (check) begin
            n_checks++;
            if (bus.s_ready !== 1'b0 || bus.wr_en_m !== 1'b0 || bus.wr_en_x !== 1'b0) begin
                n_fail++;
                $display("FAIL load_done: s_ready=%b wr_m=%b wr_x=%b want 0 0 0",
                         bus.s_ready, bus.wr_en_m, bus.wr_en_x);
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_mvalid(input int budget);
        int c = 0;
        while (bus.m_valid !== 1'b1 && c < budget) begin
            tick();
            c++;
        end
        n_checks++;
        if (bus.m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_mvalid: timeout after %0d cycles, m_valid=%b want 1", c, bus.m_valid);
        end
    endtask

    task automatic collect_outputs(input int n, input int budget);
        int got = 0;
        int cyc = 0;
        logic [15:0] e;
        while (got < n && cyc < budget) begin
            bus.m_ready = 1'b1;
            #1;
            if (bus.m_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_checks++;
                if (acc !== e) begin
                    n_fail++;
                    $display("FAIL collect result %0d: got %h want %h", got, acc, e);
                end
                got++;
            end
            tick();
            cyc++;
        end
        n_checks++;
        if (got != n) begin
            n_fail++;
            $display("FAIL collect count: got %0d want %0d", got, n);
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: s_ready=%b m_valid=%b want 1 0", bus.s_ready, bus.m_valid);
        end
        n_checks++;
        if ({bus.wr_en_m, bus.wr_en_x, bus.clear_acc, bus.en_acc} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_enables: got %b want 0000",
                     {bus.wr_en_m, bus.wr_en_x, bus.clear_acc, bus.en_acc});
        end
        n_checks++;
        if (bus.addr_m !== '0 || bus.addr_x !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: addr_m=%0d addr_x=%0d want 0 0", bus.addr_m, bus.addr_x);
        end
        do_reset();
    endtask

    task automatic test_load_compute();
        set_known_problem();
        push_expected();
        bus.m_ready = 1'b1;
        load_problem(1'b1);
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                n_checks++;
                if (bus.addr_m !== AWM'(r*SIZE+c) || bus.addr_x !== AWX'(c)) begin
                    n_fail++;
                    $display("FAIL compute_addr r%0d c%0d: addr_m=%0d addr_x=%0d want %0d %0d",
                             r, c, bus.addr_m, bus.addr_x, r*SIZE+c, c);
                end
                n_checks++;
                if (bus.clear_acc !== (c == 0) || bus.en_acc !== (c != 0) || bus.m_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL compute_acc r%0d c%0d: clear=%b en=%b m_valid=%b want %b %b 0",
                             r, c, bus.clear_acc, bus.en_acc, bus.m_valid, c == 0, c != 0);
                end
                tick();
            end
            n_checks++;
            if (bus.en_acc !== 1'b1 || bus.clear_acc !== 1'b0 || bus.m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL drain r%0d: en=%b clear=%b m_valid=%b want 1 0 0",
                         r, bus.en_acc, bus.clear_acc, bus.m_valid);
            end
            tick();
            n_checks++;
            if (bus.m_valid !== 1'b1 || acc !== exp_q[0]) begin
                n_fail++;
                $display("FAIL output r%0d: m_valid=%b data=%h want 1 %h", r, bus.m_valid, acc, exp_q[0]);
            end
            void'(exp_q.pop_front());
            tick();
        end
        n_checks++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_ready: s_ready=%b m_valid=%b want 1 0", bus.s_ready, bus.m_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [AWM-1:0] snap_m;
        logic [AWX-1:0] snap_x;
        set_known_problem();
        push_expected();
        bus.m_ready = 1'b0;
        load_problem(1'b0);
        wait_mvalid(20);
        snap_m      = bus.addr_m;
        snap_x      = bus.addr_x;
        bus.s_valid = 1'b1;
        din         = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++;
            if (bus.m_valid !== 1'b1 || acc !== 16'h0012 || bus.s_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold %0d: m_valid=%b data=%h s_ready=%b want 1 0012 0",
                         k, bus.m_valid, acc, bus.s_ready);
            end
            n_checks++;
            if ({bus.wr_en_m, bus.wr_en_x, bus.clear_acc, bus.en_acc} !== 4'b0000 ||
                bus.addr_m !== snap_m || bus.addr_x !== snap_x) begin
                n_fail++;
                $display("FAIL bp_quiet %0d: en=%b addr_m=%0d addr_x=%0d want 0000 %0d %0d",
                         k, {bus.wr_en_m, bus.wr_en_x, bus.clear_acc, bus.en_acc},
                         bus.addr_m, bus.addr_x, snap_m, snap_x);
            end
            tick();
        end
        bus.s_valid = 1'b0;
        collect_outputs(SIZE, 40);
        n_checks++;
        if (bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_reload_ready: got %b want 1", bus.s_ready);
        end
    endtask

    task automatic test_random_stall();
        logic [7:0]  wq [$];
        logic [15:0] e;
        int outs = 0;
        int accepted = 0;
        int cyc = 0;
        bit hs_in, hs_out;
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < NW; i++) begin
                prob[i] = 8'($urandom_range(0, 255));
                wq.push_back(prob[i]);
            end
            push_expected();
        end
        while (outs < 5 * SIZE && cyc < 4000) begin
            bus.s_valid = (wq.size() != 0) && ($urandom_range(0, 3) != 0);
            din         = (wq.size() != 0) ? wq[0] : 8'h00;
            bus.m_ready = 1'($urandom_range(0, 1));
            #1;
            hs_in  = bus.s_valid && bus.s_ready;
            hs_out = bus.m_valid && bus.m_ready;
            if (bus.m_valid === 1'b1 && bus.s_ready === 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL rnd_exclusive cycle %0d: s_ready=1 m_valid=1 want not both", cyc);
            end
            if (hs_out) begin
                e = exp_q.pop_front();
                n_checks++;
                if (acc !== e) begin
                    n_fail++;
                    $display("FAIL rnd_result %0d: got %h want %h", outs, acc, e);
                end
                outs++;
            end
            tick();
            if (hs_in) begin
                void'(wq.pop_front());
                accepted++;
            end
            cyc++;
        end
        bus.s_valid = 1'b0;
        n_checks++;
        if (outs != 5 * SIZE || accepted != 5 * NW) begin
            n_fail++;
            $display("FAIL rnd_counts: outputs=%0d words=%0d want %0d %0d", outs, accepted, 5 * SIZE, 5 * NW);
        end
    endtask

    task automatic test_async_reset();
        set_known_problem();
        bus.m_ready = 1'b1;
        load_problem(1'b0);
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 ||
            {bus.wr_en_m, bus.wr_en_x, bus.clear_acc, bus.en_acc} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: s_ready=%b m_valid=%b en=%b want 1 0 0000", bus.s_ready,
                     bus.m_valid, {bus.wr_en_m, bus.wr_en_x, bus.clear_acc, bus.en_acc});
        end
        do_reset();
    endtask

    task automatic test_mid_reset();
        int extra = 0;
        set_known_problem();
        push_expected();
        bus.m_ready = 1'b0;
        load_problem(1'b0);
        wait_mvalid(20);
        collect_outputs(1, 2);
        bus.m_ready = 1'b0;
        wait_mvalid(20);
        #2;
        reset = 1'b1;
        exp_q.delete();
        do_reset();
        set_known_problem();
        push_expected();
        bus.m_ready = 1'b1;
        load_problem(1'b0);
        collect_outputs(SIZE, 40);
        for (int k = 0; k < 12; k++) begin
            #1;
            if (bus.m_valid === 1'b1) extra++;
            tick();
        end
        n_checks++;
        if (extra != 0 || bus.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_tail: extra outputs=%0d s_ready=%b want 0 1", extra, bus.s_ready);
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_load_compute();
        test_backpressure();
        test_async_reset();
        test_random_stall();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mvm_ctrl.md
# mvm_ctrl

Control unit for the matrix-vector multiply (MVM) datapath. It owns the stream handshakes: an 8-bit input stream carries a SIZE×SIZE matrix in row-major order followed by a SIZE-element vector, and a 16-bit output stream carries SIZE result words. It drives the write and read addresses of the matrix and vector memories, and the accumulator clear/enable, so the datapath holds no sequencing logic of its own.

## Interface
- SIZE, 3, matrix dimension; must be ≥2
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- s_valid  in  1  input word valid
- s_ready  out  1  controller accepts an input word
- m_valid  out  1  result word valid on datapath data_out
- m_ready  in  1  downstream accepts a result word
- wr_en_m  out  1  write data_in to matrix memory at addr_m
- wr_en_x  out  1  write data_in to vector memory at addr_x
- addr_m  out  $clog2(SIZE*SIZE)  matrix memory address (write or read)
- addr_x  out  $clog2(SIZE)  vector memory address (write or read)
- clear_acc  out  1  datapath sets accumulator to 0 at the next edge
- en_acc  out  1  datapath adds the memory-output product to the accumulator at the next edge

## Operation
- The datapath memories have a 1-cycle synchronous read. The datapath's data_out is the accumulator register.
- Registered state: state ∈ {LOAD, COMPUTE, DRAIN, OUTPUT}, load_cnt (0..SIZE*SIZE+SIZE-1), row (0..SIZE-1), col (0..SIZE-1). All outputs are combinational from state, counters and s_valid.
- LOAD: s_ready=1.
  - Handshake (s_valid&s_ready) with load_cnt<SIZE*SIZE: wr_en_m=1, addr_m=load_cnt.
  - Handshake otherwise: wr_en_x=1, addr_x=load_cnt-SIZE*SIZE.
  - Each handshake increments load_cnt.
  - Handshake at load_cnt=SIZE*SIZE+SIZE-1 → COMPUTE, with row=0 and col=0.
- COMPUTE: addr_m=row*SIZE+col, addr_x=col. clear_acc=(col==0). en_acc=(col!=0). col increments each cycle. At col=SIZE-1 → DRAIN.
- DRAIN: en_acc=1 to add the last product. → OUTPUT.
- OUTPUT: m_valid=1 and held until m_ready.
  - On handshake with row<SIZE-1: row+1, col=0 → COMPUTE.
  - On handshake with row=SIZE-1: load_cnt=0 → LOAD.
- Outside LOAD: s_ready=0 and s_valid is ignored. Outside OUTPUT: m_valid=0 and m_ready is ignored.
- wr_en_m and wr_en_x are never asserted outside LOAD. clear_acc and en_acc are never asserted in the same cycle.
- Address outputs are don't-care when no enable uses them, but must never be X after reset.

## Timing
- Reset (asynchronous, no clock needed): state=LOAD, all counters 0, s_ready=1. m_valid, wr_en_m, wr_en_x, clear_acc and en_acc are 0; addr_m=0, addr_x=0.
- Input throughput: 1 word per cycle while s_valid is held high. A full load is SIZE*SIZE+SIZE cycles.
- Latency: the first m_valid rises SIZE+1 cycles after the edge that accepts the last input word. For SIZE=3 that is 4 cycles.
- Inter-row: the next m_valid rises SIZE+1 cycles after an output handshake.
- s_ready rises in the cycle after the last output handshake.
- Back-pressure: while m_valid=1 and m_ready=0, all state holds and no enable is asserted.
- Reset mid-operation (any state): immediate return to LOAD. Partial matrix, vector and results are abandoned and overwritten by the next load.
- Simultaneous events:
  - m_ready high before m_valid has no effect.
  - s_valid=0 in LOAD holds load_cnt.
  - A handshake on the final load word and the transition to COMPUTE occur on the same edge.

## Test plan
- Async reset: assert reset between clock edges during COMPUTE → s_ready=1, m_valid=0, all enables 0, before the next edge.
- Continuous load with SIZE=3, 12 words, s_valid held high:
  - wr_en_m pulses with addr_m 0..8, then wr_en_x with addr_x 0..2.
  - s_ready=0 from the cycle after the 12th handshake.
- Compute sequencing with a behavioral datapath:
  - Stimulus: matrix {1,2,3; 2,3,4; 3,4,5}, vector {3,3,3}, m_ready=1.
  - Required: addr_m 0,1,2 / 3,4,5 / 6,7,8 with addr_x 0,1,2 each row; clear_acc 1 cycle/row; en_acc 3 cycles/row.
  - Required: outputs 0x0012, 0x001B, 0x0024; first m_valid 4 cycles after the last input handshake.
- Back-pressure: m_ready=0 for 10 cycles in OUTPUT → m_valid stays 1, addresses and counters unchanged, no enables, value 0x0012 held; s_valid=1 meanwhile is not accepted.
- Random stall: random s_valid/m_ready, 5 consecutive problems → 15 outputs in order, each handshake counted once.
- Mid-run reset: reset during row 1 OUTPUT, then a full reload of the compute-sequencing stimulus → exactly 3 outputs, 0x0012, 0x001B, 0x0024.
